// File: rtl/dispatch_steer.sv
// dispatch_steer: single-entry skid buffer steering renamed instructions into
// two credit-managed issue queues (IQ0 = int/ALU/muldiv, IQ1 = load/store).
// Strict program order is kept by holding at most one instruction; local
// credit counters track free queue entries so no ready path returns from the
// queues. Younger-than-flush work held here is dropped on redirect.
module dispatch_steer #(
  parameter int PAYLOAD_W    = 160,
  parameter int IQ_DEPTH     = 8,
  parameter int ROB_SIZE_LOG = 6,
  parameter int CRD_W        = $clog2(IQ_DEPTH) + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  // dispatch side
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PAYLOAD_W-1:0]    in_payload,
  input  logic                    in_is_mem,
  input  logic                    in_robidx_flag,
  input  logic [ROB_SIZE_LOG-1:0] in_robidx,
  // issue queue 0 (integer)
  output logic                    iq0_valid,
  output logic [PAYLOAD_W-1:0]    iq0_payload,
  output logic                    iq0_robidx_flag,
  output logic [ROB_SIZE_LOG-1:0] iq0_robidx,
  input  logic [1:0]              iq0_release,
  // issue queue 1 (load/store)
  output logic                    iq1_valid,
  output logic [PAYLOAD_W-1:0]    iq1_payload,
  output logic                    iq1_robidx_flag,
  output logic [ROB_SIZE_LOG-1:0] iq1_robidx,
  input  logic [1:0]              iq1_release,
  // redirect
  input  logic                    flush_valid,
  input  logic                    flush_robidx_flag,
  input  logic [ROB_SIZE_LOG-1:0] flush_robidx,
  // status
  output logic [CRD_W-1:0]        iq0_credit,
  output logic [CRD_W-1:0]        iq1_credit,
  output logic [15:0]             stall_cnt,
  output logic                    credit_err
);

  localparam int SUM_W = CRD_W + 1;
  localparam logic [SUM_W-1:0] DEPTH_SUM = SUM_W'(IQ_DEPTH);
  localparam logic [CRD_W-1:0] DEPTH_CRD = CRD_W'(IQ_DEPTH);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } hold_state_t;

  hold_state_t             state_q, state_d;
  logic                    hold_tgt_q, hold_tgt_d;
  logic [PAYLOAD_W-1:0]    hold_payload_q, hold_payload_d;
  logic                    hold_flag_q, hold_flag_d;
  logic [ROB_SIZE_LOG-1:0] hold_robidx_q, hold_robidx_d;
  logic [CRD_W-1:0]        iq0_credit_q, iq0_credit_d;
  logic [CRD_W-1:0]        iq1_credit_q, iq1_credit_d;
  logic [15:0]             stall_cnt_q, stall_cnt_d;
  logic                    credit_err_q, credit_err_d;

  logic             hold_valid;
  logic             kill;
  logic             send;
  logic             send0;
  logic             send1;
  logic             accept;
  logic [CRD_W-1:0] tgt_credit;
  logic [SUM_W-1:0] sum0;
  logic [SUM_W-1:0] sum1;

  // Send/kill/ready decode from the hold register and the redirect inputs
  always_comb begin
    hold_valid = (state_q == FULL);
    // hold is strictly younger than the flush point (wrap-aware compare)
    kill       = flush_valid & hold_valid &
                 ((flush_robidx_flag ^ hold_flag_q) ^ (flush_robidx < hold_robidx_q));
    tgt_credit = hold_tgt_q ? iq1_credit_q : iq0_credit_q;
    send       = hold_valid & (tgt_credit != '0) & ~kill;
    send0      = send & ~hold_tgt_q;
    send1      = send & hold_tgt_q;
    in_ready   = ~flush_valid & (~hold_valid | send);
    accept     = in_valid & in_ready;
  end

  // Hold-entry FSM next state and field loading
  always_comb begin
    state_d        = state_q;
    hold_tgt_d     = hold_tgt_q;
    hold_payload_d = hold_payload_q;
    hold_flag_d    = hold_flag_q;
    hold_robidx_d  = hold_robidx_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) state_d = FULL;
      end
      FULL: begin
        if (kill)                 state_d = EMPTY;
        else if (send && !accept) state_d = EMPTY;
        else                      state_d = FULL;
      end
      default: state_d = EMPTY;
    endcase
    if (accept) begin
      hold_tgt_d     = in_is_mem;
      hold_payload_d = in_payload;
      hold_flag_d    = in_robidx_flag;
      hold_robidx_d  = in_robidx;
    end
  end

  // Credit counters: consume on send, return on release, clamp and flag overflow
  always_comb begin
    sum0         = {1'b0, iq0_credit_q} + SUM_W'(iq0_release) - SUM_W'(send0);
    sum1         = {1'b0, iq1_credit_q} + SUM_W'(iq1_release) - SUM_W'(send1);
    iq0_credit_d = sum0[CRD_W-1:0];
    iq1_credit_d = sum1[CRD_W-1:0];
    credit_err_d = credit_err_q;
    if (sum0 > DEPTH_SUM) begin
      iq0_credit_d = DEPTH_CRD;
      credit_err_d = 1'b1;
    end
    if (sum1 > DEPTH_SUM) begin
      iq1_credit_d = DEPTH_CRD;
      credit_err_d = 1'b1;
    end
  end

  // Saturating count of cycles where dispatch was blocked by a full queue
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (in_valid && !in_ready && !flush_valid && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // State registers with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= EMPTY;
      hold_tgt_q     <= 1'b0;
      hold_payload_q <= '0;
      hold_flag_q    <= 1'b0;
      hold_robidx_q  <= '0;
      iq0_credit_q   <= DEPTH_CRD;
      iq1_credit_q   <= DEPTH_CRD;
      stall_cnt_q    <= '0;
      credit_err_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_tgt_q     <= hold_tgt_d;
      hold_payload_q <= hold_payload_d;
      hold_flag_q    <= hold_flag_d;
      hold_robidx_q  <= hold_robidx_d;
      iq0_credit_q   <= iq0_credit_d;
      iq1_credit_q   <= iq1_credit_d;
      stall_cnt_q    <= stall_cnt_d;
      credit_err_q   <= credit_err_d;
    end
  end

  // Both queues see the same held bundle; only the strobe differs
  always_comb begin
    iq0_valid       = send0;
    iq1_valid       = send1;
    iq0_payload     = hold_payload_q;
    iq1_payload     = hold_payload_q;
    iq0_robidx_flag = hold_flag_q;
    iq1_robidx_flag = hold_flag_q;
    iq0_robidx      = hold_robidx_q;
    iq1_robidx      = hold_robidx_q;
    iq0_credit      = iq0_credit_q;
    iq1_credit      = iq1_credit_q;
    stall_cnt       = stall_cnt_q;
    credit_err      = credit_err_q;
  end

endmodule

// File: tb/tb_dispatch_steer.sv
// Directed self-checking bench for dispatch_steer.
module tb_dispatch_steer;

  localparam int PW = 160;
  localparam int RW = 6;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] in_payload = '0;
  logic          in_is_mem = 1'b0;
  logic          in_robidx_flag = 1'b0;
  logic [RW-1:0] in_robidx = '0;
  logic          iq0_valid, iq1_valid;
  logic [PW-1:0] iq0_payload, iq1_payload;
  logic          iq0_robidx_flag, iq1_robidx_flag;
  logic [RW-1:0] iq0_robidx, iq1_robidx;
  logic [1:0]    iq0_release = 2'd0;
  logic [1:0]    iq1_release = 2'd0;
  logic          flush_valid = 1'b0;
  logic          flush_robidx_flag = 1'b0;
  logic [RW-1:0] flush_robidx = '0;
  logic [CW-1:0] iq0_credit, iq1_credit;
  logic [15:0]   stall_cnt;
  logic          credit_err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  dispatch_steer #(.PAYLOAD_W(PW), .IQ_DEPTH(8), .ROB_SIZE_LOG(RW)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
    .in_is_mem(in_is_mem), .in_robidx_flag(in_robidx_flag), .in_robidx(in_robidx),
    .iq0_valid(iq0_valid), .iq0_payload(iq0_payload),
    .iq0_robidx_flag(iq0_robidx_flag), .iq0_robidx(iq0_robidx), .iq0_release(iq0_release),
    .iq1_valid(iq1_valid), .iq1_payload(iq1_payload),
    .iq1_robidx_flag(iq1_robidx_flag), .iq1_robidx(iq1_robidx), .iq1_release(iq1_release),
    .flush_valid(flush_valid), .flush_robidx_flag(flush_robidx_flag), .flush_robidx(flush_robidx),
    .iq0_credit(iq0_credit), .iq1_credit(iq1_credit),
    .stall_cnt(stall_cnt), .credit_err(credit_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input logic v, input logic mem, input logic [PW-1:0] p,
                       input logic f, input logic [RW-1:0] idx);
    in_valid       = v;
    in_is_mem      = mem;
    in_payload     = p;
    in_robidx_flag = f;
    in_robidx      = idx;
  endtask

  initial begin
    // ---------------- reset values ----------------
    #1 reset = 1'b1;
    #1;
    chk("rst_iq0_valid", PW'(iq0_valid), PW'(0));
    chk("rst_iq1_valid", PW'(iq1_valid), PW'(0));
    chk("rst_payload", iq0_payload, '0);
    chk("rst_iq0_credit", PW'(iq0_credit), PW'(8));
    chk("rst_iq1_credit", PW'(iq1_credit), PW'(8));
    chk("rst_stall", PW'(stall_cnt), PW'(0));
    chk("rst_err", PW'(credit_err), PW'(0));
    tick();
    reset = 1'b0;
    tick();
    chk("ready_after_rst", PW'(in_ready), PW'(1));

    // ---------------- 8 ALU instructions fill IQ0 ----------------
    for (int k = 1; k <= 8; k++) begin
      offer(1'b1, 1'b0, PW'(k), 1'b0, RW'(k));
      tick();
      chk("alu_fill_valid", PW'(iq0_valid), PW'(1));
      chk("alu_fill_payload", iq0_payload, PW'(k));
      chk("alu_fill_credit", PW'(iq0_credit), PW'(9 - k));
    end
    offer(1'b1, 1'b0, PW'(9), 1'b0, RW'(9));
    tick();
    chk("ninth_held_valid", PW'(iq0_valid), PW'(0));
    chk("ninth_ready", PW'(in_ready), PW'(0));
    chk("ninth_credit0", PW'(iq0_credit), PW'(0));
    offer(1'b1, 1'b0, PW'(10), 1'b0, RW'(10));
    tick();
    chk("stall_1", PW'(stall_cnt), PW'(1));
    tick();
    chk("stall_2", PW'(stall_cnt), PW'(2));
    iq0_release = 2'd1;
    tick();
    iq0_release = 2'd0;
    chk("ninth_sent_valid", PW'(iq0_valid), PW'(1));
    chk("ninth_sent_payload", iq0_payload, PW'(9));
    chk("ninth_sent_credit", PW'(iq0_credit), PW'(1));
    chk("stall_3", PW'(stall_cnt), PW'(3));
    chk("ready_on_send", PW'(in_ready), PW'(1));
    tick();
    chk("tenth_held", PW'(iq0_valid), PW'(0));
    chk("tenth_credit0", PW'(iq0_credit), PW'(0));
    offer(1'b0, 1'b0, '0, 1'b0, '0);
    iq0_release = 2'd2;
    tick();
    chk("rel2_credit", PW'(iq0_credit), PW'(2));
    chk("tenth_sent", iq0_payload, PW'(10));
    chk("tenth_sent_valid", PW'(iq0_valid), PW'(1));
    tick();  // send + release 2 from credit 2
    chk("send_rel_credit3", PW'(iq0_credit), PW'(3));
    iq0_release = 2'd0;
    offer(1'b1, 1'b0, PW'(11), 1'b0, RW'(11));
    tick();
    offer(1'b0, 1'b0, '0, 1'b0, '0);
    chk("eleventh_valid", PW'(iq0_valid), PW'(1));
    chk("eleventh_credit", PW'(iq0_credit), PW'(3));
    iq0_release = 2'd2;
    tick();
    chk("send_rel2_at3", PW'(iq0_credit), PW'(4));
    tick();
    chk("credit6", PW'(iq0_credit), PW'(6));
    iq0_release = 2'd1;
    tick();
    chk("credit7", PW'(iq0_credit), PW'(7));
    chk("err_before", PW'(credit_err), PW'(0));
    iq0_release = 2'd2;
    tick();
    iq0_release = 2'd0;
    chk("credit_clamp", PW'(iq0_credit), PW'(8));
    chk("err_set", PW'(credit_err), PW'(1));
    tick();
    chk("err_sticky", PW'(credit_err), PW'(1));
    chk("credit_hold8", PW'(iq0_credit), PW'(8));

    // ---------------- IQ1 full blocks following ALU ----------------
    for (int k = 1; k <= 8; k++) begin
      offer(1'b1, 1'b1, PW'(256 + k), 1'b0, RW'(k));
      tick();
      chk("mem_fill_valid", PW'(iq1_valid), PW'(1));
      chk("mem_fill_credit", PW'(iq1_credit), PW'(9 - k));
    end
    offer(1'b1, 1'b1, PW'(512), 1'b0, RW'(20));
    tick();
    offer(1'b1, 1'b0, PW'(513), 1'b0, RW'(21));
    chk("mem_blocked_iq1", PW'(iq1_valid), PW'(0));
    chk("mem_blocked_ready", PW'(in_ready), PW'(0));
    tick();
    chk("alu_behind_iq0", PW'(iq0_valid), PW'(0));
    chk("alu_behind_credit", PW'(iq0_credit), PW'(8));
    iq1_release = 2'd2;
    tick();
    iq1_release = 2'd0;
    chk("mem_first_valid", PW'(iq1_valid), PW'(1));
    chk("mem_first_payload", iq1_payload, PW'(512));
    chk("mem_first_iq0", PW'(iq0_valid), PW'(0));
    chk("mem_first_credit", PW'(iq1_credit), PW'(2));
    tick();
    offer(1'b0, 1'b0, '0, 1'b0, '0);
    chk("alu_second_valid", PW'(iq0_valid), PW'(1));
    chk("alu_second_payload", iq0_payload, PW'(513));
    chk("alu_second_iq1", PW'(iq1_valid), PW'(0));
    chk("iq1_credit_after", PW'(iq1_credit), PW'(1));
    tick();
    chk("iq0_credit7", PW'(iq0_credit), PW'(7));

    // ---------------- flush / kill ----------------
    offer(1'b1, 1'b0, PW'(768), 1'b0, RW'(5));
    tick();
    offer(1'b0, 1'b0, '0, 1'b0, '0);
    flush_valid = 1'b1; flush_robidx_flag = 1'b0; flush_robidx = RW'(3);
    #1;
    chk("kill_older_flush", PW'(iq0_valid), PW'(0));
    chk("flush_no_ready", PW'(in_ready), PW'(0));
    tick();
    flush_valid = 1'b0;
    chk("kill_empty", PW'(iq0_valid), PW'(0));
    chk("kill_credit", PW'(iq0_credit), PW'(7));

    offer(1'b1, 1'b0, PW'(769), 1'b0, RW'(5));
    tick();
    offer(1'b0, 1'b0, '0, 1'b0, '0);
    flush_valid = 1'b1; flush_robidx_flag = 1'b0; flush_robidx = RW'(7);
    #1;
    chk("survive_send", PW'(iq0_valid), PW'(1));
    chk("survive_payload", iq0_payload, PW'(769));
    tick();
    flush_valid = 1'b0;
    chk("survive_credit", PW'(iq0_credit), PW'(6));

    offer(1'b1, 1'b0, PW'(770), 1'b1, RW'(1));
    tick();
    offer(1'b0, 1'b0, '0, 1'b0, '0);
    flush_valid = 1'b1; flush_robidx_flag = 1'b0; flush_robidx = RW'(60);
    #1;
    chk("wrap_kill", PW'(iq0_valid), PW'(0));
    tick();
    flush_valid = 1'b0;
    chk("wrap_kill_credit", PW'(iq0_credit), PW'(6));
    chk("wrap_kill_empty", PW'(iq0_valid), PW'(0));

    offer(1'b1, 1'b0, PW'(771), 1'b0, RW'(9));
    tick();
    // equal tag is not younger; dispatch offer during flush must be refused
    offer(1'b1, 1'b0, PW'(772), 1'b0, RW'(10));
    flush_valid = 1'b1; flush_robidx_flag = 1'b0; flush_robidx = RW'(9);
    #1;
    chk("equal_send", PW'(iq0_valid), PW'(1));
    tick();
    flush_valid = 1'b0;
    offer(1'b0, 1'b0, '0, 1'b0, '0);
    #1;
    chk("no_accept_in_flush", PW'(iq0_valid), PW'(0));
    chk("equal_credit", PW'(iq0_credit), PW'(5));
    chk("stall_excl_flush", PW'(stall_cnt), PW'(5));

    // ---------------- stall saturation and async reset ----------------
    offer(1'b1, 1'b1, PW'(1024), 1'b0, RW'(30));
    tick();
    offer(1'b1, 1'b1, PW'(1025), 1'b0, RW'(31));
    tick();
    chk("iq1_exhausted", PW'(iq1_credit), PW'(0));
    chk("iq1_block_ready", PW'(in_ready), PW'(0));
    repeat (65540) tick();
    chk("stall_saturate", PW'(stall_cnt), PW'(16'hFFFF));
    tick();
    chk("stall_hold_sat", PW'(stall_cnt), PW'(16'hFFFF));
    #2 reset = 1'b1;
    #1;
    chk("async_rst_stall", PW'(stall_cnt), PW'(0));
    chk("async_rst_iq0cr", PW'(iq0_credit), PW'(8));
    chk("async_rst_iq1cr", PW'(iq1_credit), PW'(8));
    chk("async_rst_err", PW'(credit_err), PW'(0));
    chk("async_rst_payload", iq1_payload, '0);
    chk("async_rst_iq1v", PW'(iq1_valid), PW'(0));
    offer(1'b0, 1'b0, '0, 1'b0, '0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_ready", PW'(in_ready), PW'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
